// File: rtl/sd_clk_gen.sv
// sd_clk_gen: glitch-free programmable SD card clock generator.
// Divides pll0_250MHz by a per-speed half-period divisor and drives
// SDLocalClk from a register. Speed changes take effect only at a rising
// edge, and stop requests only after the current high phase has finished,
// so the card never sees a runt pulse.
// Optional feature macro: SDCLK_STROBE_EN adds the SDClkRise/SDClkFall
// one-cycle edge strobes used as launch/sample enables.
module sd_clk_gen #(
    parameter int NUM_SPEEDS = 4,
    parameter int SEL_W      = 2,
    parameter int DIV_W      = 10,
    parameter int DIV0       = 313,
    parameter int DIV1       = 13,
    parameter int DIV2       = 5,
    parameter int DIV3       = 3
) (
    input  logic             pll0_250MHz,
    input  logic             n_reset,
    input  logic [SEL_W-1:0] SDClkSelect,
    input  logic             SDClkEnable,
    output logic             SDLocalClk,
    output logic [SEL_W-1:0] SDClkActiveSel,
    output logic             SDClkBusy,
    output logic             SDClkRun
`ifdef SDCLK_STROBE_EN
    ,
    output logic             SDClkRise,
    output logic             SDClkFall
`endif
);

    localparam int TABLE_SIZE = 1 << SEL_W;

    typedef enum logic [1:0] {
        STOPPED  = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } sdClkState_t;

    // Divisor table covers every encodable select value so lookups never
    // index out of range; entries past NUM_SPEEDS are never selected because
    // out-of-range requests are ignored. A zero divisor is promoted to 1.
    logic [DIV_W-1:0] divTable [TABLE_SIZE];

    genvar gi;
    generate
        for (gi = 0; gi < TABLE_SIZE; gi++) begin : gDivTable
            localparam int RAW = (gi >= NUM_SPEEDS) ? DIV0 :
                                 (gi == 0) ? DIV0 :
                                 (gi == 1) ? DIV1 :
                                 (gi == 2) ? DIV2 : DIV3;
            assign divTable[gi] = (RAW == 0) ? DIV_W'(1) : DIV_W'(RAW);
        end
    endgenerate

    sdClkState_t      stateReg, stateNext;
    logic [DIV_W-1:0] cntReg, cntNext;
    logic             clkReg, clkNext;
    logic [SEL_W-1:0] activeSelReg, selNext;
    logic             busyReg, busyNext;
    logic             runReg;
    logic             selValid;
    logic             changeReq;
    logic             atRise;
    logic [DIV_W-1:0] reloadVal;
`ifdef SDCLK_STROBE_EN
    logic             riseReg, riseNext;
    logic             fallReg, fallNext;
`endif

    assign selValid = 32'(SDClkSelect) < NUM_SPEEDS;

    // Next-state, counter, clock level and speed-change arbitration.
    always_comb begin
        stateNext = stateReg;
        cntNext   = cntReg;
        clkNext   = clkReg;
        selNext   = activeSelReg;
        busyNext  = busyReg;
`ifdef SDCLK_STROBE_EN
        riseNext  = 1'b0;
        fallNext  = 1'b0;
`endif
        changeReq = selValid && (SDClkSelect != activeSelReg);
        // The only safe switch point while running: the low phase expires.
        atRise    = (stateReg == RUN) && SDClkEnable && !clkReg && (cntReg == '0);

        // Busy is raised one cycle after a request is seen; the switch is made
        // at the next safe point, or dropped if the request is withdrawn.
        if (!changeReq) begin
            busyNext = 1'b0;
        end else if (busyReg && ((stateReg == STOPPED) || atRise)) begin
            selNext  = SDClkSelect;
            busyNext = 1'b0;
        end else begin
            busyNext = 1'b1;
        end

        // Reload uses the speed in effect after this cycle, so a switch at a
        // rising edge gives the new divisor to the following high phase.
        reloadVal = divTable[selNext] - DIV_W'(1);

        case (stateReg)
            STOPPED: begin
                clkNext = 1'b0;
                cntNext = '0;
                if (SDClkEnable) begin
                    stateNext = RUN;
                    cntNext   = reloadVal;
                end
            end
            RUN: begin
                if (SDClkEnable) begin
                    if (cntReg == '0) begin
                        clkNext = !clkReg;
                        cntNext = reloadVal;
`ifdef SDCLK_STROBE_EN
                        riseNext = !clkReg;
                        fallNext = clkReg;
`endif
                    end else begin
                        cntNext = cntReg - DIV_W'(1);
                    end
                end else if (clkReg) begin
                    // Let the high phase run to completion before parking.
                    if (cntReg == '0) begin
                        clkNext   = 1'b0;
                        cntNext   = '0;
                        stateNext = STOPPED;
`ifdef SDCLK_STROBE_EN
                        fallNext  = 1'b1;
`endif
                    end else begin
                        cntNext   = cntReg - DIV_W'(1);
                        stateNext = STOPPING;
                    end
                end else begin
                    // Already low: park immediately, no truncated pulse possible.
                    stateNext = STOPPED;
                    cntNext   = '0;
                end
            end
            STOPPING: begin
                if (cntReg == '0) begin
                    clkNext   = 1'b0;
                    cntNext   = '0;
                    stateNext = STOPPED;
`ifdef SDCLK_STROBE_EN
                    fallNext  = 1'b1;
`endif
                end else begin
                    cntNext = cntReg - DIV_W'(1);
                end
            end
            default: begin
                stateNext = STOPPED;
                clkNext   = 1'b0;
                cntNext   = '0;
            end
        endcase
    end

    // State, counter and all output registers.
    always_ff @(posedge pll0_250MHz or negedge n_reset) begin
        if (!n_reset) begin
            stateReg     <= STOPPED;
            cntReg       <= '0;
            clkReg       <= 1'b0;
            activeSelReg <= '0;
            busyReg      <= 1'b0;
            runReg       <= 1'b0;
        end else begin
            stateReg     <= stateNext;
            cntReg       <= cntNext;
            clkReg       <= clkNext;
            activeSelReg <= selNext;
            busyReg      <= busyNext;
            runReg       <= (stateNext == RUN);
        end
    end

`ifdef SDCLK_STROBE_EN
    // Edge strobes, registered alongside the clock level they announce.
    always_ff @(posedge pll0_250MHz or negedge n_reset) begin
        if (!n_reset) begin
            riseReg <= 1'b0;
            fallReg <= 1'b0;
        end else begin
            riseReg <= riseNext;
            fallReg <= fallNext;
        end
    end

    assign SDClkRise = riseReg;
    assign SDClkFall = fallReg;
`endif

    assign SDLocalClk     = clkReg;
    assign SDClkActiveSel = activeSelReg;
    assign SDClkBusy      = busyReg;
    assign SDClkRun       = runReg;

endmodule

// File: tb/tb_sd_clk_gen.sv
// tb_sd_clk_gen: directed bench for sd_clk_gen with hand-computed phase
// lengths and latencies. Built with SEL_W=3 so an out-of-range select (5)
// can be driven with NUM_SPEEDS=4.
module tb_sd_clk_gen;

    localparam int SEL_W = 3;

    logic             pll0_250MHz = 1'b0;
    logic             n_reset     = 1'b0;
    logic [SEL_W-1:0] SDClkSelect = '0;
    logic             SDClkEnable = 1'b0;
    logic             SDLocalClk;
    logic [SEL_W-1:0] SDClkActiveSel;
    logic             SDClkBusy;
    logic             SDClkRun;
`ifdef SDCLK_STROBE_EN
    logic             SDClkRise;
    logic             SDClkFall;
`endif

    int vecCount = 0;
    int errCount = 0;

    always #2 pll0_250MHz = ~pll0_250MHz;

    sd_clk_gen #(
        .NUM_SPEEDS(4),
        .SEL_W     (SEL_W),
        .DIV_W     (10),
        .DIV0      (313),
        .DIV1      (13),
        .DIV2      (5),
        .DIV3      (3)
    ) dut (
        .pll0_250MHz   (pll0_250MHz),
        .n_reset       (n_reset),
        .SDClkSelect   (SDClkSelect),
        .SDClkEnable   (SDClkEnable),
        .SDLocalClk    (SDLocalClk),
        .SDClkActiveSel(SDClkActiveSel),
        .SDClkBusy     (SDClkBusy),
        .SDClkRun      (SDClkRun)
`ifdef SDCLK_STROBE_EN
        ,
        .SDClkRise     (SDClkRise),
        .SDClkFall     (SDClkFall)
`endif
    );

    task automatic checkVec(input string tag, input int obs, input int exp);
        vecCount++;
        if (obs !== exp) begin
            errCount++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // Called at a negedge: counts rising edges until SDLocalClk reads 'level'
    // at the following negedge. Returns -1 when the budget runs out.
    task automatic waitLevel(input logic level, input int maxCycles, output int n);
        n = 0;
        while (n < maxCycles) begin
            @(posedge pll0_250MHz);
            n++;
            @(negedge pll0_250MHz);
            if (SDLocalClk === level) return;
        end
        n = -1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rises, falls, prevClk;
        int sRises, sFalls, misaligned;

        // Power-up reset.
        repeat (3) @(negedge pll0_250MHz);
        checkVec("rst_clk", int'(SDLocalClk), 0);
        checkVec("rst_active", int'(SDClkActiveSel), 0);
        checkVec("rst_busy", int'(SDClkBusy), 0);
        checkVec("rst_run", int'(SDClkRun), 0);
`ifdef SDCLK_STROBE_EN
        checkVec("rst_strobes", int'({SDClkRise, SDClkFall}), 0);
`endif
        n_reset = 1'b1;
        repeat (20) @(negedge pll0_250MHz);
        checkVec("idle_clk_low", int'(SDLocalClk), 0);
        checkVec("idle_run", int'(SDClkRun), 0);

        // Enable at speed 0: first rise after 1+313 cycles, then 313/313.
        SDClkEnable = 1'b1;
        waitLevel(1'b1, 400, n);
        checkVec("first_rise_sel0", n, 314);
        checkVec("run_sel0", int'(SDClkRun), 1);
        for (int p = 0; p < 4; p++) begin
            waitLevel(1'b0, 400, n);
            checkVec("high_sel0", n, 313);
            waitLevel(1'b1, 400, n);
            checkVec("low_sel0", n, 313);
        end

        // Switch to speed 1 in the middle of a high phase.
        repeat (100) @(negedge pll0_250MHz);
        SDClkSelect = 3'd1;
        @(negedge pll0_250MHz);
        checkVec("busy_after_req", int'(SDClkBusy), 1);
        checkVec("active_before_apply", int'(SDClkActiveSel), 0);
        waitLevel(1'b0, 400, n);
        checkVec("high_rest_old_div", n, 212);
        waitLevel(1'b1, 400, n);
        checkVec("low_old_div", n, 313);
        checkVec("busy_clear_at_rise", int'(SDClkBusy), 0);
        checkVec("active_sel1", int'(SDClkActiveSel), 1);
        waitLevel(1'b0, 400, n);
        checkVec("high_sel1", n, 13);
        waitLevel(1'b1, 400, n);
        checkVec("low_sel1", n, 13);

        // Switch to speed 3, then stop mid high phase.
        SDClkSelect = 3'd3;
        waitLevel(1'b0, 400, n);
        checkVec("high_sel1_pending", n, 13);
        waitLevel(1'b1, 400, n);
        checkVec("low_sel1_pending", n, 13);
        checkVec("active_sel3", int'(SDClkActiveSel), 3);
        @(negedge pll0_250MHz);
        SDClkEnable = 1'b0;
        waitLevel(1'b0, 50, n);
        checkVec("stop_high_completes", n, 2);
        checkVec("stopped_run", int'(SDClkRun), 0);
        repeat (10) @(negedge pll0_250MHz);
        checkVec("parked_low", int'(SDLocalClk), 0);
        SDClkEnable = 1'b1;
        waitLevel(1'b1, 50, n);
        checkVec("reenable_rise_sel3", n, 4);
        checkVec("reenable_run", int'(SDClkRun), 1);

        // Stop, then change speed while stopped.
        SDClkEnable = 1'b0;
        repeat (10) @(negedge pll0_250MHz);
        checkVec("parked_low_2", int'(SDLocalClk), 0);
        SDClkSelect = 3'd2;
        @(negedge pll0_250MHz);
        checkVec("stopped_busy_pulse", int'(SDClkBusy), 1);
        checkVec("stopped_active_old", int'(SDClkActiveSel), 3);
        @(negedge pll0_250MHz);
        checkVec("stopped_busy_clear", int'(SDClkBusy), 0);
        checkVec("stopped_active_sel2", int'(SDClkActiveSel), 2);

        // Out-of-range select is ignored.
        SDClkSelect = 3'd5;
        repeat (3) begin
            @(negedge pll0_250MHz);
            checkVec("sel5_no_busy", int'(SDClkBusy), 0);
            checkVec("sel5_active_kept", int'(SDClkActiveSel), 2);
        end

        // Run at speed 2 for 100 cycles: 10 rises and 10 falls.
        SDClkEnable = 1'b1;
        waitLevel(1'b1, 50, n);
        checkVec("first_rise_sel2", n, 6);
        rises = 0; falls = 0; prevClk = 1;
        sRises = 0; sFalls = 0; misaligned = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge pll0_250MHz);
            if (SDLocalClk && prevClk == 0) rises++;
            if (!SDLocalClk && prevClk == 1) falls++;
`ifdef SDCLK_STROBE_EN
            if (SDClkRise) sRises++;
            if (SDClkFall) sFalls++;
            if (SDClkRise !== (SDLocalClk && prevClk == 0)) misaligned++;
            if (SDClkFall !== (!SDLocalClk && prevClk == 1)) misaligned++;
`endif
            prevClk = int'(SDLocalClk);
        end
        checkVec("rises_100cyc", rises, 10);
        checkVec("falls_100cyc", falls, 10);
`ifdef SDCLK_STROBE_EN
        checkVec("rise_strobes", sRises, 10);
        checkVec("fall_strobes", sFalls, 10);
        checkVec("strobe_misaligned", misaligned, 0);
`endif

        // Asynchronous reset in the middle of a high phase.
        @(negedge pll0_250MHz);
        checkVec("pre_reset_clk_high", int'(SDLocalClk), 1);
        n_reset = 1'b0;
        #1;
        checkVec("async_rst_clk", int'(SDLocalClk), 0);
        checkVec("async_rst_active", int'(SDClkActiveSel), 0);
        checkVec("async_rst_busy", int'(SDClkBusy), 0);
        checkVec("async_rst_run", int'(SDClkRun), 0);
        SDClkEnable = 1'b0;
        SDClkSelect = 3'd0;
        @(negedge pll0_250MHz);
        n_reset = 1'b1;
        repeat (10) @(negedge pll0_250MHz);
        checkVec("post_rst_low", int'(SDLocalClk), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
